// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, special register indices and
// the writeback stage state encoding.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    localparam logic [IDX_W-1:0] IDX_NONE = 4'd0;
    localparam logic [IDX_W-1:0] REG_IH   = 4'd8;
    localparam logic [IDX_W-1:0] REG_SP   = 4'd9;
    localparam logic [IDX_W-1:0] REG_RA   = 4'd10;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/writeback_stage.sv
// Final CPU pipeline stage: retires one instruction per beat into the register
// file, stalling on loads until the memory controller returns data.
//
// state       | meaning
// ------------+---------------------------------------------------------
// WB_IDLE     | nothing retiring; write outputs idle
// WB_WAIT_MEM | load accepted, waiting for memDataValid; inReady low
// WB_COMMIT   | write/T outputs valid for this single cycle
module writeback_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inRegWrite,
    input  logic [IDX_W-1:0]  inDest,
    input  logic              inMemRead,
    input  logic [DATA_W-1:0] inAluResult,
    input  logic              inTWrite,
    input  logic              inTValue,
    input  logic              flush,
    input  logic [DATA_W-1:0] memData,
    input  logic              memDataValid,
    output logic [IDX_W-1:0]  writeIndex,
    output logic [DATA_W-1:0] dataToWrite,
    output logic              tWriteEnable,
    output logic              tToWrite,
    output logic              fwdValid,
    output logic [IDX_W-1:0]  fwdIndex,
    output logic [DATA_W-1:0] fwdData,
    output logic              busy
);

    wb_state_t        state;
    logic [IDX_W-1:0] pendDest;
    logic             pendTWrite;
    logic             pendTValue;
    logic             accept;

    assign inReady = (state != WB_WAIT_MEM);
    assign accept  = inValid & inReady & ~flush;

    // Forwarding tap and busy decode purely from registered state, so they
    // carry no combinational path from the inputs.
    assign fwdValid = (state == WB_COMMIT) && (writeIndex != IDX_NONE);
    assign fwdIndex = writeIndex;
    assign fwdData  = dataToWrite;
    assign busy     = (state == WB_WAIT_MEM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= WB_IDLE;
            pendDest     <= IDX_NONE;
            pendTWrite   <= 1'b0;
            pendTValue   <= 1'b0;
            writeIndex   <= IDX_NONE;
            dataToWrite  <= '0;
            tWriteEnable <= 1'b1;
            tToWrite     <= 1'b0;
        end else begin
            case (state)
                WB_WAIT_MEM: begin
                    if (flush) begin
                        state <= WB_IDLE;
                    end else if (memDataValid) begin
                        state        <= WB_COMMIT;
                        writeIndex   <= pendDest;
                        dataToWrite  <= memData;
                        tWriteEnable <= ~pendTWrite;
                        tToWrite     <= pendTValue;
                    end
                end
                default: begin
                    if (accept && inMemRead) begin
                        // regWrite is folded into the latched destination.
                        state        <= WB_WAIT_MEM;
                        pendDest     <= inRegWrite ? inDest : IDX_NONE;
                        pendTWrite   <= inTWrite;
                        pendTValue   <= inTValue;
                        writeIndex   <= IDX_NONE;
                        tWriteEnable <= 1'b1;
                    end else if (accept) begin
                        state        <= WB_COMMIT;
                        writeIndex   <= inRegWrite ? inDest : IDX_NONE;
                        dataToWrite  <= inAluResult;
                        tWriteEnable <= ~inTWrite;
                        tToWrite     <= inTValue;
                    end else begin
                        state        <= WB_IDLE;
                        writeIndex   <= IDX_NONE;
                        tWriteEnable <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage, checked against a
// transaction-level model of the retire behaviour.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        inRegWrite = 1'b0;
    logic [3:0]  inDest = 4'd0;
    logic        inMemRead = 1'b0;
    logic [15:0] inAluResult = 16'd0;
    logic        inTWrite = 1'b0;
    logic        inTValue = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] memData = 16'd0;
    logic        memDataValid = 1'b0;
    logic [3:0]  writeIndex;
    logic [15:0] dataToWrite;
    logic        tWriteEnable;
    logic        tToWrite;
    logic        fwdValid;
    logic [3:0]  fwdIndex;
    logic [15:0] fwdData;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Model: an outstanding load (if any) and the write the register file
    // should currently see.
    bit          m_pend;
    logic [3:0]  m_pdest;
    bit          m_ptw, m_ptv;
    bit          m_commit;
    logic [3:0]  m_idx;
    logic [15:0] m_data;
    bit          m_twe, m_tt;

    writeback_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inRegWrite(inRegWrite), .inDest(inDest), .inMemRead(inMemRead),
        .inAluResult(inAluResult), .inTWrite(inTWrite), .inTValue(inTValue),
        .flush(flush), .memData(memData), .memDataValid(memDataValid),
        .writeIndex(writeIndex), .dataToWrite(dataToWrite),
        .tWriteEnable(tWriteEnable), .tToWrite(tToWrite),
        .fwdValid(fwdValid), .fwdIndex(fwdIndex), .fwdData(fwdData),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_pdest = 0; m_ptw = 0; m_ptv = 0;
        m_commit = 0; m_idx = 0; m_data = 0; m_twe = 1; m_tt = 0;
    endtask

    task automatic model_clock();
        bit acc;
        acc = inValid && !m_pend && !flush;
        m_commit = 0;
        m_idx = 0;
        m_twe = 1;
        if (m_pend) begin
            if (flush) m_pend = 0;
            else if (memDataValid) begin
                m_pend = 0; m_commit = 1;
                m_idx = m_pdest; m_data = memData; m_twe = !m_ptw; m_tt = m_ptv;
            end
        end else if (acc) begin
            if (inMemRead) begin
                m_pend = 1;
                m_pdest = inRegWrite ? inDest : 4'd0;
                m_ptw = inTWrite; m_ptv = inTValue;
            end else begin
                m_commit = 1;
                m_idx = inRegWrite ? inDest : 4'd0;
                m_data = inAluResult; m_twe = !inTWrite; m_tt = inTValue;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".writeIndex"}, 32'(writeIndex), 32'(m_idx));
        chk({tag, ".dataToWrite"}, 32'(dataToWrite), 32'(m_data));
        chk({tag, ".tWriteEnable"}, 32'(tWriteEnable), 32'(m_twe));
        chk({tag, ".tToWrite"}, 32'(tToWrite), 32'(m_tt));
        chk({tag, ".fwdValid"}, 32'(fwdValid), 32'(m_commit && m_idx != 0));
        chk({tag, ".fwdIndex"}, 32'(fwdIndex), 32'(m_idx));
        chk({tag, ".fwdData"}, 32'(fwdData), 32'(m_data));
        chk({tag, ".busy"}, 32'(busy), 32'(m_pend));
        chk({tag, ".inReady"}, 32'(inReady), 32'(!m_pend));
    endtask

    task automatic drive(input bit v, input bit rw, input logic [3:0] d, input bit ld,
                         input logic [15:0] alu, input bit tw, input bit tv,
                         input bit fl, input bit mv, input logic [15:0] md);
        inValid = v; inRegWrite = rw; inDest = d; inMemRead = ld; inAluResult = alu;
        inTWrite = tw; inTValue = tv; flush = fl; memDataValid = mv; memData = md;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        chk("reset.tWriteEnable_const", 32'(tWriteEnable), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // 1: ALU write
        drive(1, 1, 4'd3, 0, 16'h1234, 0, 0, 0, 0, 16'h0);
        step("t1_accept");
        chk("t1.writeIndex", 32'(writeIndex), 32'd3);
        chk("t1.dataToWrite", 32'(dataToWrite), 32'h1234);
        chk("t1.fwdValid", 32'(fwdValid), 32'd1);
        idle_in();
        step("t1_after");

        // 2: load with three wait cycles; inValid held high must not be taken
        drive(1, 1, 4'd9, 1, 16'h5555, 0, 0, 0, 0, 16'h0);
        step("t2_accept");
        drive(1, 1, 4'd4, 0, 16'h7777, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2.busy", 32'(busy), 32'd1);
            chk("t2.inReady", 32'(inReady), 32'd0);
            if (i < 2) step("t2_wait");
            else begin
                drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 1, 16'hBEEF);
                step("t2_data");
            end
        end
        chk("t2.writeIndex", 32'(writeIndex), 32'd9);
        chk("t2.dataToWrite", 32'(dataToWrite), 32'hBEEF);
        idle_in();
        step("t2_after");

        // 3: T write only
        drive(1, 0, 4'd5, 0, 16'h0AAA, 1, 1, 0, 0, 16'h0);
        step("t3_accept");
        chk("t3.tWriteEnable", 32'(tWriteEnable), 32'd0);
        chk("t3.tToWrite", 32'(tToWrite), 32'd1);
        chk("t3.writeIndex", 32'(writeIndex), 32'd0);
        idle_in();
        step("t3_after");
        chk("t3.tWriteEnable_idle", 32'(tWriteEnable), 32'd1);

        // 4: back-to-back non-loads
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 4'(i), 0, 16'(16'h1000 + i), 0, 0, 0, 0, 16'h0);
            step("t4_b2b");
            chk("t4.writeIndex", 32'(writeIndex), 32'(i));
        end
        idle_in();
        step("t4_after");

        // 5: flush beats memDataValid in WAIT_MEM
        drive(1, 1, 4'd7, 1, 16'h0, 0, 0, 0, 0, 16'h0);
        step("t5_accept");
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 1, 16'hDEAD);
        step("t5_flush");
        chk("t5.inReady", 32'(inReady), 32'd1);
        idle_in();
        step("t5_after");
        chk("t5.writeIndex", 32'(writeIndex), 32'd0);

        // 6: async reset mid-WAIT_MEM
        drive(1, 1, 4'd10, 1, 16'h0, 1, 1, 0, 0, 16'h0);
        step("t6_accept");
        idle_in();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("t6_reset");
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 1, 16'hCAFE);
        step("t6_release");
        chk("t6.writeIndex", 32'(writeIndex), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(9, 0) < 7, $urandom_range(1, 0) == 1, 4'($urandom_range(10, 0)),
                  $urandom_range(9, 0) < 3, 16'($urandom), $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0,
                  $urandom_range(9, 0) < 3, 16'($urandom));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
